// File: rtl/wire_seq_mult.sv
// Sequential 16x16 shift-add multiplier fed from host wire-in endpoints; product and status are registered for wire-out.
// Define WIRE_SEQ_MULT_SIGNED_EN to honour op_signed (two's-complement operands); otherwise all operations are unsigned.
module wire_seq_mult (
    input  logic        ti_clk,
    input  logic        reset,
    input  logic        go,
    input  logic [15:0] a_in,
    input  logic [15:0] b_in,
    input  logic        op_signed,
    output logic [15:0] result_lo,
    output logic [15:0] result_hi,
    output logic [15:0] status
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t      state_q, state_d;
    logic        go_q, go_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] mcand_q, mcand_d;
    logic [15:0] mplier_q, mplier_d;
    logic [4:0]  count_q, count_d;
    logic        neg_q, neg_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        res_neg_q, res_neg_d;
    logic [31:0] result_q, result_d;
    logic [7:0]  ops_q, ops_d;

    logic        start;
    logic [15:0] a_mag, b_mag;
    logic        neg_start;
    logic [31:0] fix_result;
    logic        fix_neg;

    assign start = go & ~go_q;

`ifdef WIRE_SEQ_MULT_SIGNED_EN
    // Magnitude of 0x8000 stays 0x8000 when read as 16-bit unsigned.
    assign a_mag      = (op_signed & a_in[15]) ? (16'd0 - a_in) : a_in;
    assign b_mag      = (op_signed & b_in[15]) ? (16'd0 - b_in) : b_in;
    assign neg_start  = op_signed & (a_in[15] ^ b_in[15]);
    assign fix_result = neg_q ? (32'd0 - acc_q) : acc_q;
    assign fix_neg    = neg_q & (acc_q != 32'd0);
`else
    logic [1:0] unused_signed_path;
    assign unused_signed_path = {op_signed, neg_q};
    assign a_mag      = a_in;
    assign b_mag      = b_in;
    assign neg_start  = 1'b0;
    assign fix_result = acc_q;
    assign fix_neg    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        go_d      = go;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        count_d   = count_q;
        neg_d     = neg_q;
        busy_d    = busy_q;
        done_d    = done_q;
        res_neg_d = res_neg_q;
        result_d  = result_q;
        ops_d     = ops_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = {16'd0, a_mag};
                    mplier_d = b_mag;
                    acc_d    = 32'd0;
                    count_d  = 5'd0;
                    neg_d    = neg_start;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mplier_d = mplier_q >> 1;
                mcand_d  = mcand_q << 1;
                count_d  = count_q + 5'd1;
                if (count_q == 5'd15) state_d = S_FIX;
            end
            S_FIX: begin
                result_d  = fix_result;
                res_neg_d = fix_neg;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                ops_d     = ops_q + 8'd1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // go_q resets high so a go level held through reset release is not seen as an edge.
    always_ff @(posedge ti_clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            go_q      <= 1'b1;
            acc_q     <= 32'd0;
            mcand_q   <= 32'd0;
            mplier_q  <= 16'd0;
            count_q   <= 5'd0;
            neg_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            res_neg_q <= 1'b0;
            result_q  <= 32'd0;
            ops_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            go_q      <= go_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            count_q   <= count_d;
            neg_q     <= neg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            res_neg_q <= res_neg_d;
            result_q  <= result_d;
            ops_q     <= ops_d;
        end
    end

    assign result_lo = result_q[15:0];
    assign result_hi = result_q[31:16];
    assign status    = {ops_q, count_q, res_neg_q, done_q, busy_q};

endmodule

// File: tb/tb_wire_seq_mult.sv
// Self-checking bench for wire_seq_mult: scoreboarded products, latency, start rules, reset and op-counter wrap.
module tb_wire_seq_mult;

    logic        ti_clk = 1'b0;
    logic        reset;
    logic        go;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        op_signed;
    logic [15:0] result_lo;
    logic [15:0] result_hi;
    logic [15:0] status;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  ops_exp;
    logic [31:0] prev_result;

    wire_seq_mult dut (
        .ti_clk    (ti_clk),
        .reset     (reset),
        .go        (go),
        .a_in      (a_in),
        .b_in      (b_in),
        .op_signed (op_signed),
        .result_lo (result_lo),
        .result_hi (result_hi),
        .status    (status)
    );

    always #5 ti_clk = ~ti_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
        logic signed [31:0] sp;
`ifdef WIRE_SEQ_MULT_SIGNED_EN
        if (s) begin
            sp = $signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b});
            return sp;
        end
`endif
        sp = 32'sd0;
        return {16'd0, a} * {16'd0, b} + sp;
    endfunction

    function automatic logic neg_model(input logic [15:0] a, input logic [15:0] b, input logic s,
                                       input logic [31:0] p);
`ifdef WIRE_SEQ_MULT_SIGNED_EN
        return s && (a[15] ^ b[15]) && (p != 32'd0);
`else
        return 1'b0 & s & a[0] & b[0] & p[0];
`endif
    endfunction

    task automatic tick();
        @(posedge ti_clk);
        #1;
    endtask

    // One operation: E0 checks, operand scramble, bounded wait for done, scoreboard pop.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s);
        logic [31:0] p;
        logic        neg;
        int          n;
        logic        busy_ok;
        p   = model(a, b, s);
        neg = neg_model(a, b, s, p);
        exp_q.push_back(p);
        a_in = a;
        b_in = b;
        op_signed = s;
        go = 1'b1;
        tick();
        check("busy_e0", {31'd0, status[0]}, 32'd1);
        check("hold_e0", {result_hi, result_lo}, prev_result);
        go = 1'b0;
        a_in = 16'($urandom);
        b_in = 16'($urandom);
        op_signed = 1'($urandom_range(0, 1));
        n = 0;
        busy_ok = 1'b1;
        while (!status[1] && n < 40) begin
            tick();
            n++;
            if (n < 17 && !status[0]) busy_ok = 1'b0;
        end
        check("busy_run", {31'd0, busy_ok}, 32'd1);
        check("latency", n, 32'd17);
        ops_exp = ops_exp + 8'd1;
        check("status", {16'd0, status}, {16'd0, ops_exp, 5'd16, neg, 1'b1, 1'b0});
        if (exp_q.size() > 0) check("result", {result_hi, result_lo}, exp_q.pop_front());
        prev_result = p;
        tick();
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!status[1] && n < 60) begin
            tick();
            n++;
        end
        check(tag, {31'd0, status[1]}, 32'd1);
    endtask

    initial begin
        logic [31:0] p;
        reset = 1'b1;
        go = 1'b0;
        a_in = 16'd0;
        b_in = 16'd0;
        op_signed = 1'b0;
        ops_exp = 8'd0;
        prev_result = 32'd0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("reset_result", {result_hi, result_lo}, 32'd0);
        check("reset_status", {16'd0, status}, 32'd0);

        run_op(16'h1234, 16'h5678, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 1'b0);
        run_op(16'h0000, 16'hFFFF, 1'b0);
        run_op(16'hFFFF, 16'h0003, 1'b1);
        run_op(16'h8000, 16'h8000, 1'b1);
        run_op(16'h8000, 16'h0000, 1'b1);
        run_op(16'h7FFF, 16'h8001, 1'b1);
        for (int i = 0; i < 6; i++)
            run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));

        // go held high for 40 cycles: exactly one operation.
        p = model(16'h00C3, 16'h0101, 1'b0);
        a_in = 16'h00C3;
        b_in = 16'h0101;
        op_signed = 1'b0;
        go = 1'b1;
        repeat (40) tick();
        ops_exp = ops_exp + 8'd1;
        check("held_ops", {24'd0, status[15:8]}, {24'd0, ops_exp});
        check("held_result", {result_hi, result_lo}, p);
        go = 1'b0;
        tick();
        prev_result = p;

        // Second go edge at E5 is ignored.
        p = model(16'h0321, 16'h0040, 1'b0);
        a_in = 16'h0321;
        b_in = 16'h0040;
        go = 1'b1;
        tick();
        go = 1'b0;
        repeat (4) tick();
        go = 1'b1;
        a_in = 16'hAAAA;
        tick();
        go = 1'b0;
        wait_done("e5_done");
        ops_exp = ops_exp + 8'd1;
        repeat (25) tick();
        check("e5_ops", {24'd0, status[15:8]}, {24'd0, ops_exp});
        check("e5_result", {result_hi, result_lo}, p);
        check("e5_idle", {31'd0, status[0]}, 32'd0);
        prev_result = p;

        // Reset at E8 aborts; release with go high does not start.
        a_in = 16'h0F0F;
        b_in = 16'h00FF;
        go = 1'b1;
        tick();
        repeat (7) tick();
        @(posedge ti_clk);
        #1 reset = 1'b1;
        #1;
        check("rst_mid_result", {result_hi, result_lo}, 32'd0);
        check("rst_mid_status", {16'd0, status}, 32'd0);
        repeat (3) tick();
        reset = 1'b0;
        repeat (20) tick();
        check("rst_go_high_status", {16'd0, status}, 32'd0);
        check("rst_go_high_result", {result_hi, result_lo}, 32'd0);
        go = 1'b0;
        tick();
        ops_exp = 8'd0;
        prev_result = 32'd0;

        // 256 operations from reset wrap the op counter back to zero.
        for (int i = 0; i < 256; i++)
            run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        check("wrap_ops", {24'd0, status[15:8]}, 32'd0);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
